// File: rtl/rvc_fetch_aligner_pkg.sv
// rtl/rvc_fetch_aligner_pkg.sv - shared RVC types, decode keys and parcel helpers for the fetch aligner
package rvc_fetch_aligner_pkg;

    typedef enum logic [1:0] {
        C_OP_Q0 = 2'b00,
        C_OP_Q1 = 2'b01,
        C_OP_Q2 = 2'b10,
        C_OP_32 = 2'b11
    } c_op2;

    typedef logic [2:0] c_funct3_t;

    // Decode key is {op[1:0], funct3}
    typedef enum logic [4:0] {
        C0_ADDI4SPN = 5'b00_000,
        C0_FLD      = 5'b00_001,
        C0_LW       = 5'b00_010,
        C0_FLW      = 5'b00_011,
        C0_RSVD     = 5'b00_100,
        C0_FSD      = 5'b00_101,
        C0_SW       = 5'b00_110,
        C0_FSW      = 5'b00_111,
        C1_ADDI     = 5'b01_000,
        C1_JAL      = 5'b01_001,
        C1_LI       = 5'b01_010,
        C1_LUI      = 5'b01_011,
        C1_MISC     = 5'b01_100,
        C1_J        = 5'b01_101,
        C1_BEQZ     = 5'b01_110,
        C1_BNEZ     = 5'b01_111,
        C2_SLLI     = 5'b10_000,
        C2_FLDSP    = 5'b10_001,
        C2_LWSP     = 5'b10_010,
        C2_FLWSP    = 5'b10_011,
        C2_MISC     = 5'b10_100,
        C2_FSDSP    = 5'b10_101,
        C2_SWSP     = 5'b10_110,
        C2_FSWSP    = 5'b10_111
    } rv32ic_opcode;

    localparam logic [15:0] RVC_NOP_PARCEL = 16'h0001;

    function automatic logic [1:0] rvc_len(input logic [15:0] parcel);
        return (parcel[1:0] == 2'b11) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/rvc_fetch_aligner_expander.sv
// rtl/rvc_fetch_aligner_expander.sv - combinational RV32C parcel to RV32I instruction expander
module rvc_expander (
    input  logic [15:0] parcel,
    output logic [31:0] instr,
    output logic        illegal
);
    import rvc_fetch_aligner_pkg::*;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    c_op2         quad;
    rv32ic_opcode opc;
    c_funct3_t    alu_f3;
    logic [6:0]   alu_f7;
    logic [4:0]   rd, rs2, rdp, rs1p;
    logic [11:0]  imm12, j_off;
    logic [9:0]   nzuimm, a16;
    logic [6:0]   lw_off;
    logic [7:0]   lwsp_off, swsp_off;
    logic [8:0]   b_off;
    logic [20:0]  jimm;
    logic [12:0]  bimm;

    assign quad     = c_op2'(parcel[1:0]);
    assign opc      = rv32ic_opcode'({parcel[1:0], parcel[15:13]});
    assign rd       = parcel[11:7];
    assign rs2      = parcel[6:2];
    assign rdp      = {2'b01, parcel[4:2]};
    assign rs1p     = {2'b01, parcel[9:7]};
    assign imm12    = {{6{parcel[12]}}, parcel[12], parcel[6:2]};
    assign nzuimm   = {parcel[10:7], parcel[12:11], parcel[5], parcel[6], 2'b00};
    assign lw_off   = {parcel[5], parcel[12:10], parcel[6], 2'b00};
    assign lwsp_off = {parcel[3:2], parcel[12], parcel[6:4], 2'b00};
    assign swsp_off = {parcel[8:7], parcel[12:9], 2'b00};
    assign a16      = {parcel[12], parcel[4:3], parcel[5], parcel[2], parcel[6], 4'b0000};
    assign j_off    = {parcel[12], parcel[8], parcel[10:9], parcel[6], parcel[7], parcel[2],
                       parcel[11], parcel[5:3], 1'b0};
    assign b_off    = {parcel[12], parcel[6:5], parcel[2], parcel[11:10], parcel[4:3], 1'b0};
    assign jimm     = {{9{j_off[11]}}, j_off};
    assign bimm     = {{4{b_off[8]}}, b_off};

    always_comb begin
        case (parcel[6:5])
            2'b00:   begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
            2'b01:   begin alu_f3 = 3'b100; alu_f7 = 7'b0000000; end
            2'b10:   begin alu_f3 = 3'b110; alu_f7 = 7'b0000000; end
            default: begin alu_f3 = 3'b111; alu_f7 = 7'b0000000; end
        endcase
    end

    // Anything not explicitly decoded below (FP forms, reserved slots, RV64-only) stays illegal
    always_comb begin
        instr   = '0;
        illegal = 1'b1;
        if (quad != C_OP_32) begin
            case (opc)
                C0_ADDI4SPN: if (nzuimm != '0) begin
                    instr = {2'b00, nzuimm, 5'd2, 3'b000, rdp, OP_IMM}; illegal = 1'b0;
                end
                C0_LW: begin
                    instr = {5'b0, lw_off, rs1p, 3'b010, rdp, OP_LOAD}; illegal = 1'b0;
                end
                C0_SW: begin
                    instr = {5'b0, lw_off[6:5], rdp, rs1p, 3'b010, lw_off[4:0], OP_STORE}; illegal = 1'b0;
                end
                C1_ADDI: begin
                    instr = {imm12, rd, 3'b000, rd, OP_IMM}; illegal = 1'b0;
                end
                C1_JAL: begin
                    instr = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, OP_JAL}; illegal = 1'b0;
                end
                C1_LI: begin
                    instr = {imm12, 5'd0, 3'b000, rd, OP_IMM}; illegal = 1'b0;
                end
                C1_LUI: begin
                    if (rd == 5'd2) begin
                        if (a16 != '0) begin
                            instr = {{2{a16[9]}}, a16, 5'd2, 3'b000, 5'd2, OP_IMM}; illegal = 1'b0;
                        end
                    end else if ({parcel[12], parcel[6:2]} != 6'd0) begin
                        instr = {{14{parcel[12]}}, parcel[12], parcel[6:2], rd, OP_LUI}; illegal = 1'b0;
                    end
                end
                C1_MISC: begin
                    case (parcel[11:10])
                        2'b00: if (!parcel[12]) begin
                            instr = {7'b0000000, rs2, rs1p, 3'b101, rs1p, OP_IMM}; illegal = 1'b0;
                        end
                        2'b01: if (!parcel[12]) begin
                            instr = {7'b0100000, rs2, rs1p, 3'b101, rs1p, OP_IMM}; illegal = 1'b0;
                        end
                        2'b10: begin
                            instr = {imm12, rs1p, 3'b111, rs1p, OP_IMM}; illegal = 1'b0;
                        end
                        default: if (!parcel[12]) begin
                            instr = {alu_f7, rdp, rs1p, alu_f3, rs1p, OP_REG}; illegal = 1'b0;
                        end
                    endcase
                end
                C1_J: begin
                    instr = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, OP_JAL}; illegal = 1'b0;
                end
                C1_BEQZ, C1_BNEZ: begin
                    instr = {bimm[12], bimm[10:5], 5'd0, rs1p, {2'b00, parcel[13]}, bimm[4:1], bimm[11], OP_BRANCH};
                    illegal = 1'b0;
                end
                C2_SLLI: if (!parcel[12]) begin
                    instr = {7'b0000000, rs2, rd, 3'b001, rd, OP_IMM}; illegal = 1'b0;
                end
                C2_LWSP: if (rd != 5'd0) begin
                    instr = {4'b0, lwsp_off, 5'd2, 3'b010, rd, OP_LOAD}; illegal = 1'b0;
                end
                C2_MISC: begin
                    if (rs2 != 5'd0) begin
                        instr = {7'b0, rs2, (parcel[12] ? rd : 5'd0), 3'b000, rd, OP_REG}; illegal = 1'b0;
                    end else if (parcel[12] && rd == 5'd0) begin
                        instr = 32'h0010_0073; illegal = 1'b0;
                    end else if (rd != 5'd0) begin
                        instr = {12'b0, rd, 3'b000, {4'b0, parcel[12]}, OP_JALR}; illegal = 1'b0;
                    end
                end
                C2_SWSP: begin
                    instr = {4'b0, swsp_off[7:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OP_STORE}; illegal = 1'b0;
                end
                default: begin
                    instr   = '0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// rtl/rvc_fetch_aligner.sv - parcel-buffered fetch aligner; compressed support under RVC_DECOMP_EN
module rvc_fetch_aligner #(
    parameter int          FETCH_W     = 32,
    parameter int          BUF_PARCELS = 6,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [FETCH_W-1:0] fetch_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic               out_is_c,
    output logic               out_illegal
);
    import rvc_fetch_aligner_pkg::*;

    localparam int P  = FETCH_W / 16;
    localparam int CW = $clog2(BUF_PARCELS + 1);
    localparam int IW = $clog2(BUF_PARCELS);
    localparam int SW = $clog2(P);

`ifdef RVC_DECOMP_EN
    localparam logic [SW-1:0] SKIP_MASK = '1;
`else
    localparam logic [SW-1:0] SKIP_MASK = ~SW'(1);
`endif

    logic [15:0]   buf_q [BUF_PARCELS];
    logic [15:0]   buf_d [BUF_PARCELS];
    logic [15:0]   blk   [P];
    logic [CW-1:0] cnt_q;
    logic [31:0]   pc_q;
    logic          skip_arm_q;
    logic [SW-1:0] skip_q;
    logic [15:0]   h0, h1;
    logic [1:0]    len;
    logic          have, push, pop;
    logic          unused_pc_bit;
    int            pop_n, skip_n, base, src, j, cnt_d;

    for (genvar g = 0; g < P; g++) begin : g_blk
        assign blk[g] = fetch_data[g*16 +: 16];
    end

    assign h0            = buf_q[0];
    assign h1            = buf_q[1];
    assign unused_pc_bit = flush_pc[0];
    assign have          = int'(cnt_q) >= int'(len);
    assign fetch_ready   = (int'(cnt_q) <= BUF_PARCELS - P) && !flush;
    assign out_valid     = !flush && have;
    assign out_pc        = pc_q;
    assign push          = fetch_valid && fetch_ready;
    assign pop           = out_valid && out_ready;

`ifdef RVC_DECOMP_EN
    logic [31:0] c_instr;
    logic        c_ill;

    rvc_expander u_expander (
        .parcel  (h0),
        .instr   (c_instr),
        .illegal (c_ill)
    );

    assign len         = rvc_len(h0);
    assign out_is_c    = have && (len == 2'd1);
    assign out_illegal = have && (len == 2'd1) && c_ill;
    assign out_instr   = !have         ? 32'h0 :
                         (len == 2'd2) ? {h1, h0} :
                         c_ill         ? {16'h0, h0} : c_instr;
`else
    assign len         = 2'd2;
    assign out_is_c    = 1'b0;
    assign out_illegal = have && (h0[1:0] != 2'b11);
    assign out_instr   = have ? {h1, h0} : 32'h0;
`endif

    // Survivors shift down by the popped length; the new block lands right behind them
    always_comb begin
        pop_n  = pop ? int'(len) : 0;
        skip_n = skip_arm_q ? int'(skip_q) : 0;
        base   = int'(cnt_q) - pop_n;
        src    = 0;
        j      = 0;
        for (int i = 0; i < BUF_PARCELS; i++) begin
            buf_d[i] = buf_q[i];
            src      = i + pop_n;
            j        = i - base + skip_n;
            if (src < int'(cnt_q)) begin
                buf_d[i] = buf_q[IW'(src)];
            end else if (push && j >= 0 && j < P) begin
                buf_d[i] = blk[SW'(j)];
            end
        end
        cnt_d = base + (push ? P - skip_n : 0);
    end

    // Parcels outside cnt are never issued, so the reset fill value is cosmetic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_PARCELS; i++) buf_q[i] <= RVC_NOP_PARCEL;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            skip_arm_q <= 1'b0;
            skip_q     <= '0;
        end else if (flush) begin
            cnt_q      <= '0;
            pc_q       <= {flush_pc[31:1], 1'b0};
            skip_arm_q <= 1'b1;
            skip_q     <= flush_pc[SW:1] & SKIP_MASK;
        end else begin
            for (int i = 0; i < BUF_PARCELS; i++) buf_q[i] <= buf_d[i];
            cnt_q <= CW'(cnt_d);
            if (pop)  pc_q <= pc_q + {29'd0, len, 1'b0};
            if (push) skip_arm_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb/tb_rvc_fetch_aligner.sv - scoreboard bench for rvc_fetch_aligner, both RVC_DECOMP_EN builds
module tb_rvc_fetch_aligner;
    localparam int          FETCH_W     = 32;
    localparam int          BUF_PARCELS = 6;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [31:0]        flush_pc;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [FETCH_W-1:0] fetch_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [31:0]        out_pc;
    logic               out_is_c;
    logic               out_illegal;

    rvc_fetch_aligner #(.FETCH_W(FETCH_W), .BUF_PARCELS(BUF_PARCELS), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_is_c(out_is_c), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    logic [65:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        stall_prev = 1'b0;
    logic [66:0] held = '0;

    task automatic check(input string name, input logic [66:0] got, input logic [66:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc,
                                input logic is_c, input logic ill);
        exp_q.push_back({instr, pc, is_c, ill});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev)
                check("stable_while_stalled", {out_valid, out_instr, out_pc, out_is_c, out_illegal}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_issue: got instr %h pc %h, want nothing", out_instr, out_pc);
                end else begin
                    check("issue", {1'b0, out_instr, out_pc, out_is_c, out_illegal}, {1'b0, exp_q.pop_front()});
                end
            end
            stall_prev <= out_valid && !out_ready;
            held       <= {out_valid, out_instr, out_pc, out_is_c, out_illegal};
        end
    end

    task automatic push_beat(input logic [31:0] d);
        int t = 0;
        fetch_data  = d;
        fetch_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (fetch_ready) break;
            t++;
            if (t > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL push_timeout: fetch_ready stuck 0, want 1");
                break;
            end
        end
        @(posedge clk);
        #1 fetch_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk);
            #1 t++;
        end
        check("drain_left", 67'(exp_q.size()), 67'd0);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    logic [31:0] bp_data [5] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213, 32'h0050_0293};

    initial begin
        int idx;
        logic acc;
        rst_n = 1'b0; flush = 1'b1; flush_pc = 32'h0000_0200;
        fetch_valid = 1'b0; fetch_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 flush = 1'b0;
        #1;
        check("rst_out_valid",   67'(out_valid),   67'd0);
        check("rst_fetch_ready", 67'(fetch_ready), 67'd1);
        check("rst_out_pc",      67'(out_pc),      67'(RESET_PC));
        check("rst_out_instr",   67'(out_instr),   67'd0);
        check("rst_out_is_c",    67'(out_is_c),    67'd0);
        check("rst_out_illegal", 67'(out_illegal), 67'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_pc", 67'(out_pc), 67'(RESET_PC));

        expect_instr(32'h0000_0013, 32'h0, 1'b0, 1'b0);
        push_beat(32'h0000_0013);
        check("latency_valid", 67'(out_valid), 67'd1);
        drain();

`ifdef RVC_DECOMP_EN
        expect_instr(32'h0015_0513, 32'h4, 1'b1, 1'b0);
        expect_instr(32'h0010_0513, 32'h6, 1'b1, 1'b0);
        push_beat(32'h4505_0505);
        drain();
        expect_instr(32'h0000_0013, 32'h8, 1'b1, 1'b0);
        push_beat(32'h0093_0001);
        repeat (3) @(posedge clk);
        #1 check("straddle_hold", 67'(out_valid), 67'd0);
        expect_instr(32'h00a0_0093, 32'ha, 1'b0, 1'b0);
        expect_instr(32'h0000_0013, 32'he, 1'b1, 1'b0);
        push_beat(32'h0001_00a0);
        drain();
`else
        expect_instr(32'h00a0_0093, 32'h4, 1'b0, 1'b0);
        expect_instr(32'h0020_81b3, 32'h8, 1'b0, 1'b0);
        expect_instr(32'h4505_0505, 32'hc, 1'b0, 1'b1);
        push_beat(32'h00a0_0093);
        push_beat(32'h0020_81b3);
        push_beat(32'h4505_0505);
        drain();
`endif

        out_ready   = 1'b0;
        idx         = 0;
        fetch_valid = 1'b1;
        fetch_data  = bp_data[0];
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = fetch_ready;
            @(posedge clk);
            #1 if (acc) idx++;
            if (idx < 5) fetch_data = bp_data[idx];
        end
        fetch_valid = 1'b0;
        check("beats_accepted", 67'(idx), 67'd3);
        check("full_ready", 67'(fetch_ready), 67'd0);
        expect_instr(32'h0010_0093, 32'h10, 1'b0, 1'b0);
        expect_instr(32'h0020_0113, 32'h14, 1'b0, 1'b0);
        expect_instr(32'h0030_0193, 32'h18, 1'b0, 1'b0);
        out_ready = 1'b1;
        drain();

        fetch_valid = 1'b1;
        fetch_data  = 32'h0000_0013;
        flush       = 1'b1;
        flush_pc    = 32'h0000_0300;
        #1 check("flush_ready", 67'(fetch_ready), 67'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        fetch_valid = 1'b0;
        @(posedge clk);
        #1 check("flush_drop_valid", 67'(out_valid), 67'd0);
        check("flush_pc", 67'(out_pc), 67'h300);

`ifdef RVC_DECOMP_EN
        do_flush(32'h0000_0102);
        expect_instr(32'h0000_0013, 32'h102, 1'b1, 1'b0);
        push_beat(32'h0001_0001);
        drain();
        expect_instr(32'h0000_0000, 32'h104, 1'b1, 1'b1);
        expect_instr(32'h0000_0013, 32'h106, 1'b1, 1'b0);
        push_beat(32'h0001_0000);
        expect_instr(32'h0000_6188, 32'h108, 1'b1, 1'b1);
        expect_instr(32'h0000_0013, 32'h10a, 1'b1, 1'b0);
        push_beat(32'h0001_6188);
        expect_instr(32'h0000_4002, 32'h10c, 1'b1, 1'b1);
        expect_instr(32'h00b0_0533, 32'h10e, 1'b1, 1'b0);
        push_beat(32'h852e_4002);
        drain();
`else
        do_flush(32'h0000_0104);
        expect_instr(32'h0010_0073, 32'h104, 1'b0, 1'b0);
        push_beat(32'h0010_0073);
        expect_instr(32'h0000_0000, 32'h108, 1'b0, 1'b1);
        push_beat(32'h0000_0000);
        expect_instr(32'h0001_0001, 32'h10c, 1'b0, 1'b1);
        push_beat(32'h0001_0001);
        drain();
`endif

        out_ready = 1'b0;
        push_beat(32'h0000_0013);
        check("pre_reset_valid", 67'(out_valid), 67'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 67'(out_valid),   67'd0);
        check("async_rst_pc",    67'(out_pc),      67'(RESET_PC));
        check("async_rst_ready", 67'(fetch_ready), 67'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post_async_rst_valid", 67'(out_valid), 67'd0);

        check("scoreboard_empty", 67'(exp_q.size()), 67'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
